imul_int_mul_var_lat: RTL

Parametrised, variable-latency iterative integer multiplier. It is the successor to the 32-bit fixed-latency shift-and-add multiplier and plugs into the same latency-insensitive val/rdy message interfaces. The datapath is NBITS wide, and each transaction selects signed or unsigned operands and the low or high half of the 2·NBITS product. The iteration ends early once the remaining multiplier bits are zero, so latency tracks the magnitude of operand B.

---
 rtl/imul_int_mul_var_lat.sv | 113 +++++++++++
 1 files changed

// File: rtl/imul_int_mul_var_lat.sv
// Iterative shift-and-add integer multiplier with early termination on a zero multiplier.
// Signed/unsigned operands and low/high product half are chosen per transaction.
module imul_int_mul_var_lat #(
  parameter int unsigned NBITS = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  input  logic [2*NBITS-1:0]   recv_msg,
  input  logic [1:0]           recv_mode,
  output logic                 send_val,
  input  logic                 send_rdy,
  output logic [NBITS-1:0]     send_msg
);

  localparam int unsigned PW = 2 * NBITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [PW-1:0]     a_reg;
  logic [PW-1:0]     result_reg;
  logic [NBITS-1:0]  b_reg;
  logic              neg;
  logic              hi;

  logic [NBITS-1:0]  op_a;
  logic [NBITS-1:0]  op_b;
  logic [NBITS-1:0]  abs_a;
  logic [NBITS-1:0]  abs_b;
  logic              recv_go;
  logic              b_last;
  logic [PW-1:0]     prod;

  // Operand magnitudes; the most negative value maps to 2^(NBITS-1), which still fits unsigned.
  always_comb begin
    op_a    = recv_msg[PW-1:NBITS];
    op_b    = recv_msg[NBITS-1:0];
    abs_a   = (recv_mode[0] && op_a[NBITS-1]) ? (~op_a + NBITS'(1)) : op_a;
    abs_b   = (recv_mode[0] && op_b[NBITS-1]) ? (~op_b + NBITS'(1)) : op_b;
    recv_go = recv_val && recv_rdy;
    b_last  = (b_reg >> 1) == '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      result_reg <= '0;
      neg        <= 1'b0;
      hi         <= 1'b0;
      recv_rdy   <= 1'b0;
      send_val   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (recv_go) begin
            a_reg      <= {NBITS'(0), abs_a};
            b_reg      <= abs_b;
            result_reg <= '0;
            neg        <= recv_mode[0] && (op_a[NBITS-1] ^ op_b[NBITS-1]);
            hi         <= recv_mode[1];
            recv_rdy   <= 1'b0;
            if (abs_b == '0) begin
              state    <= DONE;
              send_val <= 1'b1;
            end else begin
              state    <= CALC;
            end
          end else begin
            recv_rdy <= 1'b1;
          end
        end
        CALC: begin
          if (b_reg[0]) result_reg <= result_reg + a_reg;
          a_reg <= a_reg << 1;
          b_reg <= b_reg >> 1;
          if (b_last) begin
            state    <= DONE;
            send_val <= 1'b1;
          end
        end
        DONE: begin
          // Registers hold until the response is taken, keeping send_msg stable.
          if (send_rdy) begin
            state    <= IDLE;
            send_val <= 1'b0;
            recv_rdy <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          send_val <= 1'b0;
          recv_rdy <= 1'b0;
        end
      endcase
    end
  end

  // Sign fix-up and half select on the registered product.
  always_comb begin
    prod     = neg ? (~result_reg + PW'(1)) : result_reg;
    send_msg = '0;
    if (send_val) send_msg = hi ? prod[PW-1:NBITS] : prod[NBITS-1:0];
  end

endmodule
